// File: rtl/argmax_seq_if.sv
// Handshake bundle for argmax_seq: frame start, score stream in, result out.
// The master side drives scores and acknowledges results; the slave side is the block.
interface argmax_seq_if #(
  parameter int unsigned NrOfBits = 16
);
  logic                Start;
  logic [NrOfBits-1:0] In_Score;
  logic                In_Valid;
  logic                In_Ready;
  logic                Out_Valid;
  logic                Out_Ack;
  logic [NrOfBits-1:0] Max_Score;
  logic [3:0]          Max_Num;
  logic                Busy;

  modport master (
    output Start, In_Score, In_Valid, Out_Ack,
    input  In_Ready, Out_Valid, Max_Score, Max_Num, Busy
  );

  modport slave (
    input  Start, In_Score, In_Valid, Out_Ack,
    output In_Ready, Out_Valid, Max_Score, Max_Num, Busy
  );
endinterface

// File: rtl/argmax_seq.sv
// Sequential argmax: collects NrOfClasses unsigned scores per frame and reports the
// largest one with its index; ties keep the earliest index.
module argmax_seq #(
  parameter int unsigned NrOfBits    = 16,
  parameter int unsigned NrOfClasses = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  argmax_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  localparam logic [3:0] LastIdx = 4'(NrOfClasses - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [NrOfBits-1:0] r_max_score;
  logic [3:0]          r_max_num;
  logic                w_xfer;
  logic                w_start;
  logic                w_last;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_xfer       = 1'b0;
    w_start      = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_start = bus.Start;
        if (bus.Start) begin
          w_next_state = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        w_xfer = bus.In_Valid;
        w_last = (r_cnt == LastIdx);
        if (w_xfer && w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        // Ack wins over a coincident Start: the block only returns to IDLE here.
        if (bus.Out_Ack) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The counter saturates at the last index so it never leaves the class range.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_xfer && !w_last) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Index 0 loads unconditionally; later scores need a strict win to replace.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_max_score <= '0;
      r_max_num   <= '0;
    end else if (w_xfer && ((r_cnt == 4'd0) || (bus.In_Score > r_max_score))) begin
      r_max_score <= bus.In_Score;
      r_max_num   <= r_cnt;
    end
  end

  assign bus.In_Ready  = (r_state == ST_COLLECT);
  assign bus.Out_Valid = (r_state == ST_DONE);
  assign bus.Busy      = (r_state != ST_IDLE);
  assign bus.Max_Score = r_max_score;
  assign bus.Max_Num   = r_max_num;

endmodule

// File: tb/tb_argmax_seq.sv
// Directed-plus-random bench for argmax_seq against a max/first-index reference model.
module tb_argmax_seq;

  localparam int unsigned NB = 16;
  localparam int unsigned NC = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [NB-1:0] frame [NC];
  logic [NB-1:0] exp_score;
  logic [3:0]    exp_num;

  argmax_seq_if #(.NrOfBits(NB)) bus ();

  argmax_seq #(.NrOfBits(NB), .NrOfClasses(NC)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Result = largest value; index = first position holding that value.
  task automatic ref_model();
    logic [NB-1:0] mx;
    mx = '0;
    foreach (frame[i]) if (frame[i] > mx) mx = frame[i];
    exp_score = mx;
    exp_num   = 4'd0;
    for (int i = NC - 1; i >= 0; i--) if (frame[i] == mx) exp_num = 4'(i);
  endtask

  task automatic start_frame();
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    check("start_busy", 32'(bus.Busy), 32'd1);
    check("start_ready", 32'(bus.In_Ready), 32'd1);
  endtask

  // Feeds n scores from frame[]; random gaps and stray Start pulses on request.
  task automatic feed(input int n, input bit gaps, input bit poke_start);
    int idx = 0;
    int cyc = 0;
    bit v;
    bit rdy;
    while (idx < n && cyc < 400) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.In_Valid = v;
      bus.In_Score = v ? frame[idx] : NB'($urandom);
      bus.Start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy = bus.In_Ready;
      @(negedge clk);
      cyc++;
      if (v && rdy) idx++;
      if (idx < NC) check("no_early_valid", 32'(bus.Out_Valid), 32'd0);
    end
    bus.In_Valid = 1'b0;
    bus.Start    = 1'b0;
    check("feed_count", 32'(idx), 32'(n));
  endtask

  task automatic check_result(input string tag);
    ref_model();
    check({tag, "_valid"}, 32'(bus.Out_Valid), 32'd1);
    check({tag, "_score"}, 32'(bus.Max_Score), 32'(exp_score));
    check({tag, "_num"}, 32'(bus.Max_Num), 32'(exp_num));
  endtask

  task automatic hold_and_ack(input int n, input bit with_start);
    repeat (n) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.Out_Valid), 32'd1);
      check("hold_score", 32'(bus.Max_Score), 32'(exp_score));
      check("hold_num", 32'(bus.Max_Num), 32'(exp_num));
    end
    bus.Out_Ack = 1'b1;
    bus.Start   = with_start;
    @(negedge clk);
    bus.Out_Ack = 1'b0;
    bus.Start   = 1'b0;
    check("ack_valid_low", 32'(bus.Out_Valid), 32'd0);
    check("ack_idle", 32'(bus.Busy), 32'd0);
    check("ack_score_held", 32'(bus.Max_Score), 32'(exp_score));
    check("ack_num_held", 32'(bus.Max_Num), 32'(exp_num));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.Start    = 1'b0;
    bus.In_Valid = 1'b0;
    bus.In_Score = '0;
    bus.Out_Ack  = 1'b0;
    #2;
    check("rst_ready", 32'(bus.In_Ready), 32'd0);
    check("rst_valid", 32'(bus.Out_Valid), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_score", 32'(bus.Max_Score), 32'd0);
    check("rst_num", 32'(bus.Max_Num), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.Busy), 32'd0);

    // Basic frame, then a long unacked hold and Ack+Start together.
    frame = '{16'd5, 16'd9, 16'd3, 16'd12, 16'd7, 16'd1, 16'd0, 16'd2, 16'd11, 16'd4};
    start_frame();
    feed(NC, 1'b0, 1'b0);
    check_result("basic");
    check("basic_score_const", 32'(bus.Max_Score), 32'd12);
    check("basic_num_const", 32'(bus.Max_Num), 32'd3);
    hold_and_ack(5, 1'b1);
    @(negedge clk);
    check("ackstart_still_idle", 32'(bus.Busy), 32'd0);

    // Tie: earlier index must win; previous result held until first transfer.
    foreach (frame[i]) frame[i] = 16'h0010;
    frame[2] = 16'h0100;
    frame[6] = 16'h0100;
    start_frame();
    check("held_before_xfer", 32'(bus.Max_Score), 32'd12);
    feed(NC, 1'b0, 1'b0);
    check_result("tie");
    check("tie_num_const", 32'(bus.Max_Num), 32'd2);
    hold_and_ack(1, 1'b0);

    // Extreme value at the last index with random stalls.
    foreach (frame[i]) frame[i] = '0;
    frame[9] = 16'hFFFF;
    start_frame();
    feed(NC, 1'b1, 1'b0);
    check_result("stall");
    check("stall_num_const", 32'(bus.Max_Num), 32'd9);
    hold_and_ack(2, 1'b0);

    // Reset pulsed mid-frame abandons the partial result.
    foreach (frame[i]) frame[i] = NB'($urandom);
    start_frame();
    feed(4, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.In_Ready), 32'd0);
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_score", 32'(bus.Max_Score), 32'd0);
    check("midrst_num", 32'(bus.Max_Num), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.In_Valid = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("postrst_no_valid", 32'(bus.Out_Valid), 32'd0);
      check("postrst_not_ready", 32'(bus.In_Ready), 32'd0);
    end
    bus.In_Valid = 1'b0;
    foreach (frame[i]) frame[i] = 16'd7;
    start_frame();
    feed(NC, 1'b0, 1'b0);
    check_result("equal");
    check("equal_num_const", 32'(bus.Max_Num), 32'd0);
    hold_and_ack(1, 1'b0);

    // In_Valid in IDLE and Start during COLLECT are ignored.
    bus.In_Valid = 1'b1;
    bus.In_Score = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      check("idle_ignores_valid", 32'(bus.Busy), 32'd0);
    end
    foreach (frame[i]) frame[i] = NB'($urandom_range(0, 1000));
    start_frame();
    feed(NC, 1'b1, 1'b1);
    check_result("ignored");
    hold_and_ack(1, 1'b0);

    // Random frames; narrow value range makes ties frequent.
    for (int f = 0; f < 20; f++) begin
      foreach (frame[i]) frame[i] = (f % 2 == 0) ? NB'($urandom_range(0, 7)) : NB'($urandom);
      start_frame();
      feed(NC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_result("rand");
      hold_and_ack(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
